// File: rtl/conv_pe_ctrl_pkg.sv
// Shared types for the convolution PE-chain sequencer: FSM state encoding and byte width.
package conv_pe_ctrl_pkg;

  localparam int CONV_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STORE  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } conv_ctrl_state_t;

endpackage

// File: rtl/conv_pe_ctrl_cnt.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-value compare.
module conv_pe_ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         hit_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/conv_pe_ctrl.sv
// Sequencer for one NUM_PE-long MAC chain: weight load, store pulse, activation stream, zero drain.
// Optional CONV_PE_CTRL_KEEP_W_EN adds cfg_keep_w to reuse stored weights and skip the load.
module conv_pe_ctrl
  import conv_pe_ctrl_pkg::*;
#(
  parameter int NUM_PE = 9,
  parameter int LEN_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       cfg_len,
`ifdef CONV_PE_CTRL_KEEP_W_EN
  input  logic                   cfg_keep_w,
`endif
  input  logic                   w_valid,
  input  logic [CONV_DATA_W-1:0] w_data,
  output logic                   w_ready,
  input  logic                   x_valid,
  input  logic [CONV_DATA_W-1:0] x_data,
  output logic                   x_ready,
  output logic [CONV_DATA_W-1:0] arr_x,
  output logic                   arr_shift_en,
  output logic                   arr_store_en,
  output logic                   y_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int LDW = $clog2(NUM_PE + 1);
  localparam int SW  = LEN_W + 1;

  conv_ctrl_state_t state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic             y_valid_q, y_valid_d;
  logic             w_hs, x_hs, drain, strm_shift;
  logic             ld_hit, s_hit;
  logic [LDW-1:0]   ld_cnt;
  logic [SW-1:0]    s_cnt, s_nx, s_hi, len_m1;

  assign w_ready    = (state_q == ST_LOAD_W);
  assign x_ready    = (state_q == ST_STREAM);
  assign w_hs       = w_ready & w_valid;
  assign x_hs       = x_ready & x_valid;
  assign drain      = (state_q == ST_DRAIN);
  assign strm_shift = x_hs | drain;

  assign arr_shift_en = w_hs | strm_shift;
  assign arr_x        = w_hs ? w_data : (x_hs ? x_data : '0);
  assign arr_store_en = (state_q == ST_STORE);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign y_valid      = y_valid_q;

  // Load handshakes and drain cycles share one counter; it restarts on every state change.
  conv_pe_ctrl_cnt #(.W(LDW)) u_ld_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q != state_d),
    .en_i   (w_hs | drain),
    .term_i (LDW'(NUM_PE - 1)),
    .cnt_o  (ld_cnt),
    .hit_o  (ld_hit)
  );

  // Shift counter s spans STREAM and DRAIN so it can place the result window.
  assign len_m1 = {1'b0, len_q} - SW'(1);
  conv_pe_ctrl_cnt #(.W(SW)) u_s_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == ST_IDLE),
    .en_i   (strm_shift),
    .term_i (len_m1),
    .cnt_o  (s_cnt),
    .hit_o  (s_hit)
  );

  assign s_nx      = s_cnt + SW'(1);
  assign s_hi      = {1'b0, len_q} + SW'(NUM_PE - 1);
  assign y_valid_d = strm_shift && (s_nx >= SW'(NUM_PE)) && (s_nx <= s_hi);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef CONV_PE_CTRL_KEEP_W_EN
          if (cfg_keep_w) state_d = (cfg_len == '0) ? ST_DONE : ST_STREAM;
          else            state_d = ST_LOAD_W;
`else
          state_d = ST_LOAD_W;
`endif
        end
      end
      ST_LOAD_W: if (w_hs && ld_hit) state_d = ST_STORE;
      ST_STORE:  state_d = (len_q == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (x_hs && s_hit) state_d = ST_DRAIN;
      ST_DRAIN:  if (ld_cnt == LDW'(NUM_PE - 2)) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_valid_q <= y_valid_d;
      if (state_q == ST_IDLE && start) len_q <= cfg_len;
    end
  end

endmodule

// File: tb/tb_conv_pe_ctrl.sv
// Bench for conv_pe_ctrl with NUM_PE=3: job table with per-job event counts plus a cycle scoreboard for y_valid.
module tb_conv_pe_ctrl;

  localparam int NP = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_len;
`ifdef CONV_PE_CTRL_KEEP_W_EN
  logic        cfg_keep_w;
`endif
  logic        w_valid, x_valid;
  logic [7:0]  w_data, x_data;
  logic        w_ready, x_ready;
  logic [7:0]  arr_x;
  logic        arr_shift_en, arr_store_en, y_valid, busy, done;

  conv_pe_ctrl #(.NUM_PE(NP), .LEN_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_len      (cfg_len),
`ifdef CONV_PE_CTRL_KEEP_W_EN
    .cfg_keep_w   (cfg_keep_w),
`endif
    .w_valid      (w_valid),
    .w_data       (w_data),
    .w_ready      (w_ready),
    .x_valid      (x_valid),
    .x_data       (x_data),
    .x_ready      (x_ready),
    .arr_x        (arr_x),
    .arr_shift_en (arr_shift_en),
    .arr_store_en (arr_store_en),
    .y_valid      (y_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    bit stall;
    bit noise;
    bit keep;
    int exp_wrdy;
    int exp_store;
    int exp_drain;
    int exp_busy;
    int exp_xrdy;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] wts [3];
  int   st_wrdy, st_xrdy, st_store, st_done, st_busy, st_wsh, st_xsh, st_drain, st_y;
  int   cur_len, s_tb, cyc;
  int   sbq[$];
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int len, input bit stall, input bit noise, input bit keep,
                     input int wrdy, input int store, input int drn, input int bsy, input int xrdy);
    vec_t v;
    v.len = len; v.stall = stall; v.noise = noise; v.keep = keep;
    v.exp_wrdy = wrdy; v.exp_store = store; v.exp_drain = drn;
    v.exp_busy = bsy; v.exp_xrdy = xrdy;
    tbl.push_back(v);
  endtask

  function automatic int outs_vec();
    return int'({arr_x, arr_shift_en, arr_store_en, w_ready, x_ready, y_valid, busy, done});
  endfunction

  // Monitor: per-cycle data-path checks, event counts and the y_valid scoreboard.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      cyc++;
      if (busy)         st_busy++;
      if (w_ready)      st_wrdy++;
      if (x_ready)      st_xrdy++;
      if (arr_store_en) st_store++;
      if (done)         st_done++;
      if (w_ready || x_ready) begin
        chk("shift_en", int'(arr_shift_en), w_ready ? int'(w_valid) : int'(x_valid));
        chk("arr_x", int'(arr_x), (w_ready && w_valid) ? int'(w_data) :
                                  ((x_ready && x_valid) ? int'(x_data) : 0));
      end else if (arr_shift_en) begin
        chk("drain_x", int'(arr_x), 0);
      end
      if (arr_shift_en && w_ready)               st_wsh++;
      if (arr_shift_en && x_ready)               st_xsh++;
      if (arr_shift_en && !w_ready && !x_ready)  st_drain++;
      if (arr_shift_en && !w_ready) begin
        s_tb++;
        if (s_tb >= NP && s_tb <= cur_len + NP - 1) sbq.push_back(cyc + 1);
      end
      if (y_valid) begin
        st_y++;
        if (sbq.size() == 0) chk("y_unexpected", 1, 0);
        else                 chk("y_cycle", cyc, sbq.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    start = 1'b0; w_valid = 1'b0; x_valid = 1'b0; w_data = '0; x_data = '0;
  endtask

  task automatic run_job(input vec_t v, input int abort_at);
    int  widx, xidx;
    bit  tog, seen_done, aborted;
    st_wrdy = 0; st_xrdy = 0; st_store = 0; st_done = 0; st_busy = 0;
    st_wsh = 0; st_xsh = 0; st_drain = 0; st_y = 0;
    cur_len = v.len; s_tb = 0; cyc = 0; sbq.delete();
    widx = 0; xidx = 0; tog = 1'b1; seen_done = 1'b0; aborted = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 16'(v.len);
`ifdef CONV_PE_CTRL_KEEP_W_EN
    cfg_keep_w = v.keep;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && !seen_done && !aborted; c++) begin
      w_valid = (widx < 3);
      w_data  = (widx < 3) ? wts[widx] : 8'hA5;
      x_valid = (xidx < v.len) && (!v.stall || tog);
      x_data  = 8'(64 + 3 * xidx);
      if (v.noise && x_ready && xidx == 1) begin
        start = 1'b1; w_valid = 1'b1; cfg_len = 16'd9;
      end else begin
        start = 1'b0;
      end
      if (abort_at >= 0 && xidx == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", outs_vec(), 0);
        mon_en = 1'b0;
        @(posedge clk); #1;
        chk("rst_held_outs", outs_vec(), 0);
        idle_inputs();
        rst_n = 1'b1;
        aborted = 1'b1;
      end else begin
        @(negedge clk);
        if (w_valid && w_ready && widx < 3) widx++;
        if (x_valid && x_ready) xidx++;
        if (x_ready) tog = !tog;
        if (done) seen_done = 1'b1;
        @(posedge clk); #1;
      end
    end
    idle_inputs();
    mon_en = 1'b0;
    if (!aborted) begin
      chk("timeout", int'(seen_done), 1);
      chk("w_ready_cycles", st_wrdy, v.exp_wrdy);
      chk("w_shifts", st_wsh, v.exp_wrdy);
      chk("store_pulses", st_store, v.exp_store);
      chk("x_shifts", st_xsh, v.len);
      chk("x_ready_cycles", st_xrdy, v.exp_xrdy);
      chk("drain_shifts", st_drain, v.exp_drain);
      chk("y_count", st_y, v.len);
      chk("done_pulses", st_done, 1);
      chk("busy_cycles", st_busy, v.exp_busy);
      chk("sb_left", sbq.size(), 0);
    end
  endtask

  initial begin
    vec_t ab;
    wts[0] = 8'sd2; wts[1] = -8'sd1; wts[2] = 8'sd3;
    rst_n = 1'b0; cfg_len = '0;
`ifdef CONV_PE_CTRL_KEEP_W_EN
    cfg_keep_w = 1'b0;
`endif
    idle_inputs();

    //    len stall noise keep wrdy store drain busy xrdy
    add(4, 0, 0, 0, 3, 1, 2, 11, 4);
    add(4, 1, 0, 0, 3, 1, 2, 14, 7);
    add(0, 0, 0, 0, 3, 1, 0,  5, 0);
    add(4, 0, 1, 0, 3, 1, 2, 11, 4);
    add(1, 0, 0, 0, 3, 1, 2,  8, 1);
    add(5, 1, 1, 0, 3, 1, 2, 16, 9);
`ifdef CONV_PE_CTRL_KEEP_W_EN
    add(4, 0, 0, 1, 0, 0, 2,  7, 4);
    add(0, 0, 0, 1, 0, 0, 0,  1, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs_vec(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outs", outs_vec(), 0);

    foreach (tbl[i]) run_job(tbl[i], -1);

    ab = tbl[0];
    ab.len = 6;
    run_job(ab, 2);
    run_job(tbl[0], -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pe_ctrl.md
# conv_pe_ctrl

Sequencing controller for one linear chain of `NUM_PE` MAC processing elements in the convolution layer. It loads a kernel by shifting weight bytes through the chain's x-path and commits them with a single store pulse. It then streams activation bytes into the chain under a valid/ready handshake, and drains the pipeline with zero bytes. It flags each cycle in which the chain's final accumulation output holds a valid result.

## Interface
- `NUM_PE`, default 9: number of PEs in the driven chain (≥2).
- `LEN_W`, default 16: width of the activation-count configuration.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a job; sampled only in IDLE.
- `cfg_len` in LEN_W: number of activation bytes in the job; latched on accepted `start`.
- `w_valid` in 1, `w_data` in 8, `w_ready` out 1: weight byte stream (signed bytes).
- `x_valid` in 1, `x_data` in 8, `x_ready` out 1: activation byte stream (unsigned bytes).
- `arr_x` out 8: data byte to the first PE's x input.
- `arr_shift_en` out 1: chain-wide shift enable.
- `arr_store_en` out 1: chain-wide weight-store enable.
- `y_valid` out 1: the last PE's accumulation output is a valid result this cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at job end.

## Operation
- FSM states: IDLE → LOAD_W → STORE → STREAM → DRAIN → DONE → IDLE.
- **IDLE**
  - `start`=1 latches `cfg_len` and moves to LOAD_W.
  - `start` in any other state is ignored.
- **LOAD_W**
  - `w_ready`=1.
  - Each handshake (`w_valid & w_ready`) sets `arr_shift_en`=1 and `arr_x`=`w_data` in the same cycle.
  - After exactly `NUM_PE` handshakes, move to STORE. The first byte accepted ends up in the last PE.
- **STORE**
  - One cycle with `arr_store_en`=1 and `arr_shift_en`=0.
  - Next state: STREAM, or DONE if the latched length is 0.
- **STREAM**
  - `x_ready`=1.
  - Each handshake sets `arr_shift_en`=1 and `arr_x`=`x_data`.
  - `x_valid` low stalls the chain (no shift, `arr_x`=0).
  - After `cfg_len` handshakes, move to DRAIN.
- **DRAIN**
  - `arr_shift_en`=1 with `arr_x`=0 every cycle for `NUM_PE-1` cycles, then move to DONE.
- **DONE**
  - One cycle with `done`=1, then return to IDLE.
- **Result flag**
  - A shift counter `s` counts STREAM and DRAIN shifts.
  - `y_valid` is a register set the cycle after any shift that leaves `NUM_PE ≤ s ≤ cfg_len+NUM_PE-1`; otherwise it is 0.
  - Result j (0-based) is flagged after shift j+NUM_PE.
- **Counters**
  - Load/drain counter: `$clog2(NUM_PE+1)` bits.
  - Length/shift counters: LEN_W+1 bits, so no wrap for maximum `cfg_len` plus drain.
- **Ignored inputs**
  - `w_valid` outside LOAD_W and `x_valid` outside STREAM are ignored; the matching ready is 0.
- There is no backpressure on results: downstream must accept every `y_valid` cycle.

## Timing
- Reset value of every output: 0.
  - Async reset returns the FSM to IDLE at any point, including mid-job; counters clear.
  - The chain shares `rst_n`, so weights are lost too.
- `arr_x`, `arr_shift_en`, `w_ready` and `x_ready` are combinational from state and the handshake, giving zero-cycle latency into the PE registers.
- `arr_store_en`, `busy`, `done` and `y_valid` depend only on registers.
- Minimum job length is `NUM_PE` + 1 + `cfg_len` + (`NUM_PE`-1) + 1 cycles after start, given no stalls.
- The `start` cycle itself is IDLE; LOAD_W begins on the next cycle.

## Configuration
- `CONV_PE_CTRL_KEEP_W_EN`
  - Defined: adds input port `cfg_keep_w` (1 bit), latched with `start`. When it is 1, IDLE goes directly to STREAM, skipping LOAD_W and STORE and reusing the stored weights.
  - Undefined: the port does not exist, and every job loads weights.

## Structure
- Package `conv_pe_ctrl_pkg`: state enum `conv_ctrl_state_t` and byte-width constant `CONV_DATA_W` = 8.
- Sub-module `conv_pe_ctrl_cnt`: parameterised-width up-counter with clear, enable and terminal-compare output. Instantiated for the load/drain count and the stream count.

## Test plan
All scenarios use `NUM_PE`=3.
- Reset mid-STREAM → all outputs 0 immediately, and the next `start` begins a fresh LOAD_W.
- `cfg_len`=4, weights {2,-1,3}, continuous streams:
  - 3 weight shifts, then 1 store pulse, then 4 activation shifts, then 2 zero shifts.
  - `y_valid` high for exactly 4 cycles; `done` pulses once.
- `x_valid` toggling 1/0 during STREAM:
  - `arr_shift_en` follows handshakes only.
  - `y_valid` count is still 4, and no result is flagged during a stall.
- `cfg_len`=0:
  - Load and store complete, then DONE.
  - No `x_ready`, `y_valid` never asserts, and `done` pulses once.
- `start` and `w_valid` pulsed during STREAM → no effect on the FSM or counters.
- With `CONV_PE_CTRL_KEEP_W_EN` defined and `cfg_keep_w`=1:
  - Zero `w_ready` cycles and no `arr_store_en`.
  - Results match the previously stored weights.
